sink_capture: RTL
=================

# sink_capture

Parametrised FIFO-to-memory capture engine: drains an upstream FIFO and writes each word to a sequential window of a sample memory starting at a configurable base address. Extends the simulation sink used at the interpolator output with configurable data/address widths, a base offset, a ring (continuous, wrap-around) mode, abort, and status outputs. Sits between the interpolator output FIFO and the capture RAM/readback path.

## Interface
- DATA_WIDTH, 16, FIFO word / memory data width
- ADDR_WIDTH, 7, memory address width
- CONFIG_WIDTH, 32, width of ilen and count_o

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  start a capture; sampled only in IDLE
- abort_i  in  1  stop issuing reads; sampled in RUN
- mode_i  in  1  0 = single-shot, 1 = ring; latched at start
- base_i  in  ADDR_WIDTH  first write address; latched at start
- ilen  in  CONFIG_WIDTH  words per capture (single) / window length (ring); latched at start
- Empty_i  in  1  upstream FIFO empty
- data_i  in  DATA_WIDTH  FIFO read data, valid the cycle after Read_Enable_o
- Read_Enable_o  out  1  FIFO pop request
- Write_Enable_o  out  1  memory write strobe
- addr  out  ADDR_WIDTH  memory write address
- wdata_o  out  DATA_WIDTH  memory write data (direct from data_i)
- busy_o  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- wrap_o  out  1  one-cycle pulse on the write at the last window address (ring mode)
- count_o  out  CONFIG_WIDTH  writes since last start, saturating at all-ones

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_i=1 latches mode, base, ilen; clears count_o, read offset, write offset. ilen=0 -> DONE; else -> RUN. start_i in any other state ignored.
- RUN: Read_Enable_o = !Empty_i && !abort_i && (mode=ring || issued < ilen). Combinational from state, Empty_i, abort_i, issued counter.
  - single: when issued reaches ilen, or abort_i=1 -> DRAIN.
  - ring: runs until abort_i=1 -> DRAIN.
- DRAIN: no reads; waits one cycle for any outstanding write to complete -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Write path: Write_Enable_o is Read_Enable_o registered; wdata_o = data_i. Each write: addr = base + write_offset (mod 2^ADDR_WIDTH), then write_offset increments, count_o increments (saturating).
- Ring wrap: when write_offset = ilen-1, wrap_o=1 on that write and write_offset returns to 0. Single mode never asserts wrap_o.
- Address arithmetic modulo 2^ADDR_WIDTH; base+offset overflow wraps silently.
- Empty_i high in RUN: no read, no error; state held.
- abort_i and Empty_i low same cycle: no read issued that cycle.
- abort_i outside RUN ignored.

## Timing
- Reset (rst=1 at an edge): state IDLE; Read_Enable_o, Write_Enable_o, busy_o, done, wrap_o = 0; addr, count_o, offsets = 0; latched config = 0. In-flight write discarded. Reset dominates every other input.
- start_i sampled at edge E0 -> RUN from E0; first Read_Enable_o possible in cycle after E0.
- Read in cycle k -> Write_Enable_o, addr, wdata_o valid in cycle k+1.
- Single-shot, FIFO never empty, ilen=N: reads in N consecutive cycles, writes lag by one, DRAIN 1 cycle, done one cycle after the last write. Start-edge to done-pulse: N+2 cycles.
- ilen=0: done in the cycle after the start edge, no reads/writes.
- busy_o registered with state; low in IDLE and DONE.
- Throughput: one word per cycle while Empty_i=0.

## Test plan
- Single, base=5, ilen=4, FIFO holds 0xA1..0xA4, never empty -> writes addr 5,6,7,8 with A1..A4 in consecutive cycles; done pulse 1 cycle after last write; count_o=4; exactly 4 reads.
- Single, ilen=6, Empty_i toggles every other cycle -> 6 reads only on Empty_i=0 cycles, addr 0..5 gap-free; done once; no read after the 6th.
- Ring, base=120, ilen=10, ADDR_WIDTH=7, 25 words then abort -> addr sequence 120..127,0,1 repeating; wrap_o on 3rd-from-end... on 10th and 20th writes; count_o=25; done after drain.
- ilen=0 start -> done next cycle, no Read_Enable_o, count_o=0; start_i during RUN of a second capture ignored (config unchanged).
- Abort while a read is outstanding -> that word still written, no further reads, DRAIN then done.
- rst asserted mid-RUN with a read outstanding -> next cycle all outputs 0, no write issued; fresh start afterwards behaves as first scenario.

Source files
------------

// File: rtl/sink_capture.sv
// sink_capture: drains an upstream FIFO into a sequential window of a sample
// memory. Single-shot mode writes ilen words then stops; ring mode keeps
// writing around a window of ilen addresses until aborted.
module sink_capture #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 7,
  parameter int CONFIG_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    mode_i,
  input  logic [ADDR_WIDTH-1:0]   base_i,
  input  logic [CONFIG_WIDTH-1:0] ilen,
  input  logic                    Empty_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    Read_Enable_o,
  output logic                    Write_Enable_o,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic                    busy_o,
  output logic                    done,
  output logic                    wrap_o,
  output logic [CONFIG_WIDTH-1:0] count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    mode_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CONFIG_WIDTH-1:0] ilen_q;
  logic [CONFIG_WIDTH-1:0] issued_q;   // reads issued (single-shot only)
  logic [CONFIG_WIDTH-1:0] wr_off_q;   // offset of the next write in the window
  logic [CONFIG_WIDTH-1:0] count_q;
  logic                    we_q;

  logic rd_en;
  logic last_rd;
  logic wrap_hit;
  logic start_hit;

  // Read request, last-read lookahead and ring wrap detection.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rd_en     = (state_q == S_RUN) && !Empty_i && !abort_i &&
                (mode_q || (issued_q < ilen_q));
    last_rd   = rd_en && !mode_q && ((issued_q + CONFIG_WIDTH'(1)) == ilen_q);
    wrap_hit  = we_q && mode_q && (wr_off_q == (ilen_q - CONFIG_WIDTH'(1)));
    start_hit = (state_q == S_IDLE) && start_i;
  end

  // Next-state logic; the final single-shot read moves straight to DRAIN so
  // done lands one cycle after the last write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = (ilen == '0) ? S_DONE : S_RUN;
      S_RUN:   if (abort_i || last_rd || (!mode_q && (issued_q >= ilen_q)))
                 state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched configuration, counters and the registered write strobe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      base_q   <= '0;
      ilen_q   <= '0;
      issued_q <= '0;
      wr_off_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= rd_en;
      if (start_hit) begin
        mode_q   <= mode_i;
        base_q   <= base_i;
        ilen_q   <= ilen;
        issued_q <= '0;
        wr_off_q <= '0;
        count_q  <= '0;
      end else begin
        if (rd_en && !mode_q) issued_q <= issued_q + CONFIG_WIDTH'(1);
        if (we_q) begin
          wr_off_q <= wrap_hit ? '0 : wr_off_q + CONFIG_WIDTH'(1);
          if (count_q != '1) count_q <= count_q + CONFIG_WIDTH'(1);
        end
      end
    end
  end

  // Output decode; address arithmetic wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    Read_Enable_o  = rd_en;
    Write_Enable_o = we_q;
    addr           = base_q + wr_off_q[ADDR_WIDTH-1:0];
    wdata_o        = data_i;
    busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    wrap_o         = wrap_hit;
    count_o        = count_q;
  end

endmodule
